tgt_enthdrx_detector: RTL and testbench

Target-side detector for the I3C ENTHDRx broadcast CCC, and the generalised successor of the single-mode ENTHDR0 target path. It watches synchronised SCL/SDA in SDR mode and ACKs the 7'h7E/W broadcast address. It then decodes the CCC byte plus its T-bit, validates odd parity and a per-mode enable mask, and hands the bus to the selected HDR engine (DDR, TSP, TSL, BT...) until that engine reports done.

---
 rtl/tgt_enthdrx_detector.sv | 201 ++++++++++++++++++++
 tb/tb_tgt_enthdrx_detector.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tgt_enthdrx_detector.sv
// I3C target-side ENTHDRx detector: ACKs the 7'h7E/W broadcast, decodes the CCC and T-bit,
// and hands the bus to the selected HDR engine until it reports done.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting 7-bit address + RnW on SCL rises
// ACK       | driving ACK low for the 9th address clock
// CCC       | shifting 8 CCC bits + T-bit
// CHECK     | one-cycle parity / mode-enable decision
// HDR       | selected HDR engine owns the bus until i_hdr_done
// WAIT_STOP | frame ignored, waiting for STOP or Sr
module tgt_enthdrx_detector #(
    parameter logic [6:0] BCAST_ADDR   = 7'h7E,
    parameter logic [7:0] MODE_EN_MASK = 8'b0000_0001,
    parameter int         MODE_W       = 3
) (
    input  logic              i_sdr_clk,
    input  logic              i_sdr_rst_n,
    input  logic              i_en,
    input  logic              i_scl,
    input  logic              i_sda,
    output logic              o_sda_oe,
    output logic              o_sda,
    output logic              o_hdr_en,
    output logic [MODE_W-1:0] o_hdr_mode,
    input  logic              i_hdr_done,
    output logic              o_parity_err,
    output logic              o_unsup_mode,
    output logic              o_busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ACK       = 3'd2;
    localparam logic [2:0] S_CCC       = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_HDR       = 3'd5;
    localparam logic [2:0] S_WAIT_STOP = 3'd6;

    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [8:0] shift_reg;
    logic       prev_scl;
    logic       prev_sda;

    logic       ev_start;
    logic       ev_stop;
    logic       ev_rise;
    logic       ev_fall;
    logic [3:0] cnt_inc;
    logic [7:0] ccc;
    logic       t_bit;
    logic       is_enthdr;
    logic       t_ok;
    logic [7:0] addr_byte;

    assign ev_start  = prev_scl & i_scl & prev_sda & ~i_sda;
    assign ev_stop   = prev_scl & i_scl & ~prev_sda & i_sda;
    assign ev_rise   = ~prev_scl & i_scl;
    assign ev_fall   = prev_scl & ~i_scl;
    assign cnt_inc   = (bit_cnt == 4'hF) ? bit_cnt : bit_cnt + 4'd1;
    assign ccc       = shift_reg[8:1];
    assign t_bit     = shift_reg[0];
    assign is_enthdr = (ccc[7:3] == 5'b00100);
    assign t_ok      = (t_bit == ~^ccc);
    assign addr_byte = {shift_reg[6:0], i_sda};

    assign o_sda  = 1'b0;
    assign o_busy = (state != S_IDLE);

    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            state        <= S_IDLE;
            bit_cnt      <= 4'd0;
            shift_reg    <= 9'd0;
            prev_scl     <= 1'b1;
            prev_sda     <= 1'b1;
            o_sda_oe     <= 1'b0;
            o_hdr_en     <= 1'b0;
            o_hdr_mode   <= '0;
            o_parity_err <= 1'b0;
            o_unsup_mode <= 1'b0;
        end else begin
            prev_scl     <= i_scl;
            prev_sda     <= i_sda;
            o_parity_err <= 1'b0;
            o_unsup_mode <= 1'b0;
            if (!i_en) begin
                state    <= S_IDLE;
                bit_cnt  <= 4'd0;
                o_sda_oe <= 1'b0;
                o_hdr_en <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ev_start) begin
                            state   <= S_ADDR;
                            bit_cnt <= 4'd0;
                        end
                    end
                    S_ADDR: begin
                        if (ev_start) begin
                            bit_cnt <= 4'd0;
                        end else if (ev_stop) begin
                            state   <= S_IDLE;
                            bit_cnt <= 4'd0;
                        end else if (ev_rise) begin
                            shift_reg <= {shift_reg[7:0], i_sda};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                state   <= (addr_byte == {BCAST_ADDR, 1'b0}) ? S_ACK : S_WAIT_STOP;
                            end else begin
                                bit_cnt <= cnt_inc;
                            end
                        end
                    end
                    S_ACK: begin
                        // bit_cnt==0 before the 9th rise, nonzero after it
                        if (ev_start) begin
                            state    <= S_ADDR;
                            bit_cnt  <= 4'd0;
                            o_sda_oe <= 1'b0;
                        end else if (ev_stop) begin
                            state    <= S_IDLE;
                            bit_cnt  <= 4'd0;
                            o_sda_oe <= 1'b0;
                        end else if (ev_rise) begin
                            bit_cnt <= cnt_inc;
                        end else if (ev_fall) begin
                            if (bit_cnt == 4'd0) begin
                                o_sda_oe <= 1'b1;
                            end else begin
                                o_sda_oe <= 1'b0;
                                state    <= S_CCC;
                                bit_cnt  <= 4'd0;
                            end
                        end
                    end
                    S_CCC: begin
                        if (ev_start) begin
                            state   <= S_ADDR;
                            bit_cnt <= 4'd0;
                        end else if (ev_stop) begin
                            state   <= S_IDLE;
                            bit_cnt <= 4'd0;
                        end else if (ev_rise) begin
                            shift_reg <= {shift_reg[7:0], i_sda};
                            if (bit_cnt == 4'd8) begin
                                state   <= S_CHECK;
                                bit_cnt <= 4'd0;
                            end else begin
                                bit_cnt <= cnt_inc;
                            end
                        end
                    end
                    S_CHECK: begin
                        bit_cnt <= 4'd0;
                        if (!is_enthdr) begin
                            state <= S_WAIT_STOP;
                        end else if (!t_ok) begin
                            o_parity_err <= 1'b1;
                            state        <= S_WAIT_STOP;
                        end else if (!MODE_EN_MASK[ccc[2:0]]) begin
                            o_unsup_mode <= 1'b1;
                            state        <= S_WAIT_STOP;
                        end else begin
                            o_hdr_mode <= MODE_W'(ccc[2:0]);
                            o_hdr_en   <= 1'b1;
                            state      <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        if (i_hdr_done) begin
                            o_hdr_en <= 1'b0;
                            state    <= S_WAIT_STOP;
                            bit_cnt  <= 4'd0;
                        end
                    end
                    S_WAIT_STOP: begin
                        o_sda_oe <= 1'b0;
                        if (ev_stop) begin
                            state   <= S_IDLE;
                            bit_cnt <= 4'd0;
                        end else if (ev_start) begin
                            state   <= S_ADDR;
                            bit_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        bit_cnt  <= 4'd0;
                        o_sda_oe <= 1'b0;
                        o_hdr_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tgt_enthdrx_detector.sv
// Bench for tgt_enthdrx_detector: two instances (default mask and mask 8'h03) on one
// wired-AND bus, driven by a table of ENTHDRx frames plus directed corner sequences.
module tb_tgt_enthdrx_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       scl;
    logic       sda_m;
    logic       done;
    logic       sda_bus;

    logic       oe_a, sdo_a, hen_a, par_a, uns_a, busy_a;
    logic [2:0] mode_a;
    logic       oe_b, sdo_b, hen_b, par_b, uns_b, busy_b;
    logic [2:0] mode_b;

    int total = 0;
    int bad   = 0;

    int pa_cnt, ua_cnt, pb_cnt, ub_cnt;
    int en_first_a, en_first_b;

    always #5 clk = ~clk;

    // open-drain bus: any driver pulls low
    assign sda_bus = sda_m & ~(oe_a & ~sdo_a) & ~(oe_b & ~sdo_b);

    tgt_enthdrx_detector dut_a (
        .i_sdr_clk(clk), .i_sdr_rst_n(rst_n), .i_en(en), .i_scl(scl), .i_sda(sda_bus),
        .o_sda_oe(oe_a), .o_sda(sdo_a), .o_hdr_en(hen_a), .o_hdr_mode(mode_a),
        .i_hdr_done(done), .o_parity_err(par_a), .o_unsup_mode(uns_a), .o_busy(busy_a)
    );

    tgt_enthdrx_detector #(.MODE_EN_MASK(8'h03)) dut_b (
        .i_sdr_clk(clk), .i_sdr_rst_n(rst_n), .i_en(en), .i_scl(scl), .i_sda(sda_bus),
        .o_sda_oe(oe_b), .o_sda(sdo_b), .o_hdr_en(hen_b), .o_hdr_mode(mode_b),
        .i_hdr_done(done), .o_parity_err(par_b), .o_unsup_mode(uns_b), .o_busy(busy_b)
    );

    typedef struct {
        logic [7:0] ccc;
        logic       t;
        logic       en_a;
        logic [2:0] mode_a;
        logic       par_a;
        logic       uns_a;
        logic       en_b;
        logic [2:0] mode_b;
        logic       par_b;
        logic       uns_b;
    } vec_t;

    vec_t vecs[9];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic bus_start();
        scl = 1'b1; sda_m = 1'b1; tick(2);
        sda_m = 1'b0; tick(2);
        scl = 1'b0; tick(1);
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; tick(1);
        scl = 1'b1; tick(2);
        sda_m = 1'b0; tick(2);
        scl = 1'b0; tick(1);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(1);
        scl = 1'b1; tick(2);
        sda_m = 1'b1; tick(2);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; tick(1);
        scl = 1'b1; tick(2);
        scl = 1'b0; tick(1);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
    endtask

    task automatic ack_bit(input int exp);
        sda_m = 1'b1; tick(1);
        chk("ack_oe_a_low", oe_a, exp);
        chk("ack_oe_b_low", oe_b, exp);
        scl = 1'b1; tick(2);
        chk("ack_oe_a_high", oe_a, exp);
        chk("ack_oe_b_high", oe_b, exp);
        scl = 1'b0; tick(2);
        chk("ack_release_a", oe_a, 0);
        chk("ack_release_b", oe_b, 0);
    endtask

    // address FC + ACK + CCC + T; counts pulses and first hdr_en cycle after the 9th CCC rise
    task automatic frame(input logic [7:0] c, input logic t);
        write_byte(8'hFC);
        ack_bit(1);
        write_byte(c);
        sda_m = t; tick(1);
        scl = 1'b1;
        pa_cnt = 0; ua_cnt = 0; pb_cnt = 0; ub_cnt = 0;
        en_first_a = -1; en_first_b = -1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            pa_cnt += int'(par_a); ua_cnt += int'(uns_a);
            pb_cnt += int'(par_b); ub_cnt += int'(uns_b);
            if (hen_a && en_first_a < 0) en_first_a = k;
            if (hen_b && en_first_b < 0) en_first_b = k;
        end
        scl = 1'b0; tick(1);
    endtask

    task automatic exit_hdr();
        done = 1'b1; tick(1);
        done = 1'b0; tick(1);
        chk("exit_hen_a", hen_a, 0);
        chk("exit_hen_b", hen_b, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h20, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{8'h21, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
        vecs[2] = '{8'h22, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[3] = '{8'h20, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[4] = '{8'h07, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[5] = '{8'h07, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[6] = '{8'h27, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
        vecs[7] = '{8'h21, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[8] = '{8'h28, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b1; scl = 1'b1; sda_m = 1'b1; done = 1'b0;
        tick(3);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_oe_a", oe_a, 0);
        chk("rst_hen_a", hen_a, 0);
        chk("rst_mode_a", mode_a, 0);
        chk("rst_pulses_a", {par_a, uns_a}, 0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        tick(2);

        // ACK must not appear before the fall that ends the 8th address clock
        bus_start();
        chk("start_busy_a", busy_a, 1);
        for (int i = 7; i >= 1; i--) write_bit(1'(8'hFC >> i));
        sda_m = 1'b0; tick(1);
        scl = 1'b1; tick(2);
        chk("pre_ack_oe_a", oe_a, 0);
        scl = 1'b0; tick(1);
        ack_bit(1);
        bus_stop();
        chk("abort_busy_a", busy_a, 0);

        for (int v = 0; v < 9; v++) begin
            bus_start();
            frame(vecs[v].ccc, vecs[v].t);
            chk($sformatf("v%0d_par_a", v), pa_cnt, int'(vecs[v].par_a));
            chk($sformatf("v%0d_uns_a", v), ua_cnt, int'(vecs[v].uns_a));
            chk($sformatf("v%0d_par_b", v), pb_cnt, int'(vecs[v].par_b));
            chk($sformatf("v%0d_uns_b", v), ub_cnt, int'(vecs[v].uns_b));
            chk($sformatf("v%0d_hen_a", v), hen_a, int'(vecs[v].en_a));
            chk($sformatf("v%0d_hen_b", v), hen_b, int'(vecs[v].en_b));
            chk($sformatf("v%0d_lat_a", v), en_first_a, vecs[v].en_a ? 1 : -1);
            chk($sformatf("v%0d_lat_b", v), en_first_b, vecs[v].en_b ? 1 : -1);
            if (vecs[v].en_a) chk($sformatf("v%0d_mode_a", v), mode_a, int'(vecs[v].mode_a));
            if (vecs[v].en_b) chk($sformatf("v%0d_mode_b", v), mode_b, int'(vecs[v].mode_b));
            chk($sformatf("v%0d_busy_a", v), busy_a, 1);
            exit_hdr();
            if (vecs[v].en_b) chk($sformatf("v%0d_mode_keep_b", v), mode_b, int'(vecs[v].mode_b));
            bus_stop();
            chk($sformatf("v%0d_idle_a", v), busy_a, 0);
            chk($sformatf("v%0d_idle_b", v), busy_b, 0);
        end

        // non-broadcast address then repeated-START recovery
        bus_start();
        write_byte(8'h50);
        ack_bit(0);
        chk("nack_wait_a", busy_a, 1);
        bus_rstart();
        frame(8'h20, 1'b0);
        chk("sr_hen_a", hen_a, 1);
        chk("sr_hen_b", hen_b, 1);
        chk("sr_mode_a", mode_a, 0);
        // STOP is ignored while the HDR engine owns the bus
        bus_stop();
        chk("hdr_stop_ign_a", hen_a, 1);
        chk("hdr_stop_busy_a", busy_a, 1);
        exit_hdr();
        bus_stop();
        chk("sr_idle_a", busy_a, 0);

        // enable dropped while driving ACK
        bus_start();
        write_byte(8'hFC);
        tick(1);
        chk("en_ack_oe_a", oe_a, 1);
        en = 1'b0;
        tick(1);
        chk("en_drop_oe_a", oe_a, 0);
        chk("en_drop_oe_b", oe_b, 0);
        chk("en_drop_busy_a", busy_a, 0);
        en = 1'b1;
        bus_stop();

        // enable dropped together with done while in HDR
        bus_start();
        frame(8'h21, 1'b1);
        chk("en_done_hen_b", hen_b, 1);
        en = 1'b0; done = 1'b1;
        tick(1);
        en = 1'b1; done = 1'b0;
        chk("en_done_busy_b", busy_b, 0);
        chk("en_done_hen_b0", hen_b, 0);
        bus_stop();

        // async reset during HDR
        bus_start();
        frame(8'h21, 1'b1);
        chk("pre_rst_hen_b", hen_b, 1);
        chk("pre_rst_mode_b", mode_b, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_hen_b", hen_b, 0);
        chk("arst_mode_b", mode_b, 0);
        chk("arst_busy_b", busy_b, 0);
        chk("arst_oe_b", oe_b, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
